// File: rtl/riu2_pkg.sv
// Shared definitions for the riu2 histogram slice: bin count, FSM states, sizing helper.
package riu2_pkg;

    localparam int RIU2_NUM_BINS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        READY = 2'd2
    } riu2_state_e;

    function automatic int riu2_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/riu2_histogram_if.sv
// Code-stream input, frame control and read port of the riu2 histogram.
interface riu2_histogram_if #(parameter int BIN_W = 10);

    logic             done_i;
    logic             progress_done_i;
    logic [3:0]       data_i;
    logic             clear_i;
    logic [3:0]       rd_addr_i;
    logic [BIN_W-1:0] rd_data_o;
    logic             hist_valid_o;
    logic [BIN_W-1:0] sample_cnt_o;
    logic             code_err_o;
    logic             overrun_o;

    modport master (
        output done_i, progress_done_i, data_i, clear_i, rd_addr_i,
        input  rd_data_o, hist_valid_o, sample_cnt_o, code_err_o, overrun_o
    );

    modport slave (
        input  done_i, progress_done_i, data_i, clear_i, rd_addr_i,
        output rd_data_o, hist_valid_o, sample_cnt_o, code_err_o, overrun_o
    );

endinterface

// File: rtl/riu2_bin_counter.sv
// Single histogram counter with clear and increment; saturates when RIU2_HIST_SAT_EN
// is defined, otherwise wraps modulo 2^BIN_W.
module riu2_bin_counter #(
    parameter int BIN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [BIN_W-1:0] o_cnt
);

    logic [BIN_W-1:0] r_cnt;

    // A clear with a coincident increment starts the new frame at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? BIN_W'(1) : '0;
        end else if (i_inc) begin
`ifdef RIU2_HIST_SAT_EN
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
`else
            r_cnt <= r_cnt + 1'b1;
`endif
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/riu2_histogram.sv
// Per-frame histogram of riu2 LBP codes with freeze/clear control and registered read port.
// Counter overflow behaviour selected by RIU2_HIST_SAT_EN (saturate) vs. default (wrap).
module riu2_histogram
    import riu2_pkg::*;
#(
    parameter int ROWS     = 30,
    parameter int COLS     = 30,
    parameter int NUM_BINS = RIU2_NUM_BINS,
    parameter int BIN_W    = riu2_clog2(ROWS * COLS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    riu2_histogram_if.slave    bus
);

    riu2_state_e      r_state;
    riu2_state_e      w_next;
    logic             r_code_err;
    logic             r_overrun;
    logic             w_code_err_nxt;
    logic             w_overrun_nxt;
    logic             w_valid_code;
    logic             w_live;
    logic             w_clr;
    logic             w_inc;
    logic [BIN_W-1:0] w_bins [NUM_BINS];
    logic [BIN_W-1:0] w_sample_cnt;
    logic [BIN_W-1:0] w_rd_sel;
    logic [BIN_W-1:0] r_rd_data;

    assign w_valid_code = {28'd0, bus.data_i} < 32'(NUM_BINS);
    assign w_clr        = (r_state == READY) && bus.clear_i;
    // Samples are live while collecting, or when a clear reopens the frame in the same cycle.
    assign w_live       = (r_state != READY) || w_clr;
    assign w_inc        = bus.done_i && w_valid_code && w_live;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_code_err <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_code_err <= w_code_err_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_code_err_nxt = r_code_err;
        w_overrun_nxt  = r_overrun;
        case (r_state)
            IDLE: begin
                if (bus.progress_done_i) w_next = READY;
                else if (w_inc)          w_next = ACCUM;
            end
            ACCUM: begin
                if (bus.progress_done_i) w_next = READY;
            end
            READY: begin
                if (bus.clear_i) begin
                    w_next        = w_inc ? ACCUM : IDLE;
                    w_overrun_nxt = 1'b0;
                end else if (bus.done_i) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_clr) w_code_err_nxt = 1'b0;
        if (bus.done_i && !w_valid_code && w_live) w_code_err_nxt = 1'b1;
    end

    for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
        riu2_bin_counter #(.BIN_W(BIN_W)) u_bin (
            .clk   (clk),
            .rst   (rst),
            .i_clr (w_clr),
            .i_inc (w_inc && (bus.data_i == 4'(g))),
            .o_cnt (w_bins[g])
        );
    end

    riu2_bin_counter #(.BIN_W(BIN_W)) u_sample_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_inc (w_inc),
        .o_cnt (w_sample_cnt)
    );

    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (bus.rd_addr_i == 4'(i)) w_rd_sel = w_bins[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_data <= '0;
        else     r_rd_data <= w_rd_sel;
    end

    assign bus.rd_data_o    = r_rd_data;
    assign bus.hist_valid_o = (r_state == READY);
    assign bus.sample_cnt_o = w_sample_cnt;
    assign bus.code_err_o   = r_code_err;
    assign bus.overrun_o    = r_overrun;

endmodule

// File: tb/tb_riu2_histogram.sv
// Self-checking bench for riu2_histogram: directed table, frame sequences, random vs. model.
module tb_riu2_histogram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riu2_histogram_if #(.BIN_W(10)) bus ();
    riu2_histogram_if #(.BIN_W(4))  bus4 ();

    riu2_histogram #(.ROWS(30), .COLS(30), .NUM_BINS(10), .BIN_W(10)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    riu2_histogram #(.ROWS(3), .COLS(5), .NUM_BINS(10), .BIN_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a frame is an array of tallies plus a frozen flag.
    int m_bins [10];
    int m_cnt;
    bit m_frozen;
    bit m_err;
    bit m_ovr;

    typedef struct {
        bit         d;
        bit         pd;
        bit         c;
        logic [3:0] dat;
        logic [3:0] a;
        int         e_cnt;
        bit         e_hv;
        bit         e_err;
        bit         e_ovr;
        int         e_rd;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_bins[i] = 0;
        m_cnt = 0; m_frozen = 0; m_err = 0; m_ovr = 0;
    endtask

    task automatic model_take(input logic [3:0] dat);
        if (dat < 10) begin
            m_bins[dat] = (m_bins[dat] + 1) % 1024;
            m_cnt = (m_cnt + 1) % 1024;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic model_step(input bit d, input bit pd, input logic [3:0] dat, input bit c);
        if (m_frozen) begin
            if (c) begin
                for (int i = 0; i < 10; i++) m_bins[i] = 0;
                m_cnt = 0; m_err = 0; m_ovr = 0; m_frozen = 0;
                if (d) model_take(dat);
            end else if (d) begin
                m_ovr = 1;
            end
        end else begin
            if (d) model_take(dat);
            if (pd) m_frozen = 1;
        end
    endtask

    task automatic cycle(input bit d, input bit pd, input logic [3:0] dat, input bit c,
                         input logic [3:0] a);
        int exp_rd;
        bus.done_i = d; bus.progress_done_i = pd; bus.data_i = dat;
        bus.clear_i = c; bus.rd_addr_i = a;
        exp_rd = (a < 10) ? m_bins[a] : 0;
        @(posedge clk);
        model_step(d, pd, dat, c);
        #1;
        chk("rd_data", 32'(bus.rd_data_o), 32'(exp_rd));
        chk("sample_cnt", 32'(bus.sample_cnt_o), 32'(m_cnt));
        chk("hist_valid", 32'(bus.hist_valid_o), 32'(m_frozen));
        chk("code_err", 32'(bus.code_err_o), 32'(m_err));
        chk("overrun", 32'(bus.overrun_o), 32'(m_ovr));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd2,  4'd2,  1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'd12, 4'd2,  1, 1'b0, 1'b1, 1'b0, 1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'd2,  4'd2,  2, 1'b0, 1'b1, 1'b0, 1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd15, 4'd2,  2, 1'b0, 1'b1, 1'b0, 2};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'd2,  4'd2,  3, 1'b0, 1'b1, 1'b0, 2};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'd2,  4'd2,  4, 1'b1, 1'b1, 1'b0, 3};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd2,  4, 1'b1, 1'b1, 1'b0, 4};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  4, 1'b1, 1'b1, 1'b0, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'd5,  4'd5,  4, 1'b1, 1'b1, 1'b1, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd5,  4, 1'b1, 1'b1, 1'b1, 0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 4'd7,  4'd7,  1, 1'b0, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd7,  1, 1'b0, 1'b0, 1'b0, 1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd14, 1, 1'b1, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd7,  0, 1'b0, 1'b0, 1'b0, 1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd3,  0, 1'b1, 1'b0, 1'b0, 0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd14, 0, 1'b1, 1'b0, 1'b0, 0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  0, 1'b0, 1'b0, 1'b0, 0};

        bus.done_i = 0; bus.progress_done_i = 0; bus.data_i = 0;
        bus.clear_i = 0; bus.rd_addr_i = 0;
        bus4.done_i = 0; bus4.progress_done_i = 0; bus4.data_i = 0;
        bus4.clear_i = 0; bus4.rd_addr_i = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hist_valid", 32'(bus.hist_valid_o), 32'd0);
        chk("rst_sample_cnt", 32'(bus.sample_cnt_o), 32'd0);
        rst = 1'b0;

        // Reset mid-frame
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 4'd3, 1'b0, 4'd3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_sample_cnt", 32'(bus.sample_cnt_o), 32'd0);
        chk("midrst_rd_data", 32'(bus.rd_data_o), 32'd0);
        chk("midrst_hist_valid", 32'(bus.hist_valid_o), 32'd0);
        chk("midrst_code_err", 32'(bus.code_err_o), 32'd0);
        chk("midrst_overrun", 32'(bus.overrun_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd3);
        cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd3);
        chk("midrst_bin3", 32'(bus.rd_data_o), 32'd0);

        // Normal frame: 90 samples, end-of-frame on the last one
        for (int k = 0; k < 90; k++)
            cycle(1'b1, (k == 89), 4'(k % 10), 1'b0, 4'(k % 10));
        chk("norm_hist_valid", 32'(bus.hist_valid_o), 32'd1);
        chk("norm_sample_cnt", 32'(bus.sample_cnt_o), 32'd90);
        for (int b = 0; b < 10; b++) begin
            cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'(b));
            chk($sformatf("norm_bin%0d", b), 32'(bus.rd_data_o), 32'd9);
        end
        cycle(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);

        // Directed table: invalid codes, overrun, clear collision, empty frame
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].d, tbl[i].pd, tbl[i].dat, tbl[i].c, tbl[i].a);
            chk($sformatf("tbl%0d_cnt", i), 32'(bus.sample_cnt_o), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_hv", i), 32'(bus.hist_valid_o), 32'(tbl[i].e_hv));
            chk($sformatf("tbl%0d_err", i), 32'(bus.code_err_o), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_ovr", i), 32'(bus.overrun_o), 32'(tbl[i].e_ovr));
            chk($sformatf("tbl%0d_rd", i), 32'(bus.rd_data_o), 32'(tbl[i].e_rd));
        end

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [3:0] dat;
            dat = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), dat,
                  ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)));
        end

        // Overflow on the narrow instance: 20 samples into a 4-bit bin
        bus.done_i = 0; bus.progress_done_i = 0; bus.clear_i = 0;
        bus4.done_i = 1; bus4.data_i = 4'd1; bus4.rd_addr_i = 4'd1;
        repeat (20) @(posedge clk);
        #1;
        bus4.done_i = 0; bus4.progress_done_i = 1;
        @(posedge clk);
        #1;
        bus4.progress_done_i = 0;
        @(posedge clk);
        #1;
        chk("ovf_hist_valid", 32'(bus4.hist_valid_o), 32'd1);
`ifdef RIU2_HIST_SAT_EN
        chk("ovf_bin1", 32'(bus4.rd_data_o), 32'd15);
        chk("ovf_sample_cnt", 32'(bus4.sample_cnt_o), 32'd15);
`else
        chk("ovf_bin1", 32'(bus4.rd_data_o), 32'd4);
        chk("ovf_sample_cnt", 32'(bus4.sample_cnt_o), 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
